// File: rtl/clock_sequencer_if.sv
// Control/status bundle between the CPU clock sequencer and its controller.
// The master side issues divisor and hold requests; the slave side is the sequencer.
interface clock_sequencer_if;
  logic [1:0] div_sel;
  logic       div_req;
  logic       hold_req;
  logic       clk_out;
  logic       oe;
  logic       cpu_reset_n;
  logic       div_ack;
  logic       hold_ack;
  logic       busy;

  modport master (
    output div_sel, div_req, hold_req,
    input  clk_out, oe, cpu_reset_n, div_ack, hold_ack, busy
  );

  modport slave (
    input  div_sel, div_req, hold_req,
    output clk_out, oe, cpu_reset_n, div_ack, hold_ack, busy
  );
endinterface

// File: rtl/clock_sequencer.sv
// CPU clock sequencer: divided clock generation, power-on CPU reset stretch,
// glitch-free divisor switching and clock-line release to an external master.
module clock_sequencer #(
  parameter int         RESET_CYCLES = 1024,
  parameter int         GAP_CYCLES   = 4,
  parameter logic [1:0] DIV_RESET    = 2'd1
) (
  input  logic              clk_in,
  input  logic              reset,
  clock_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(RESET_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    STARTUP,
    RUN,
    DRAIN,
    PARK,
    RESUME,
    HELD
  } state_t;

  state_t             state_reg;
  logic               clk_out_reg;
  logic               oe_reg;
  logic               cpu_reset_n_reg;
  logic               div_ack_reg;
  logic               hold_ack_reg;
  logic               busy_reg;
  logic [1:0]         div_reg;
  logic [1:0]         pend_div_reg;
  logic               pend_valid_reg;
  logic               hold_flag_reg;
  logic               ack_pend_reg;
  logic [3:0]         hp_cnt_reg;
  logic [CNT_W-1:0]   cyc_cnt_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;

  logic [3:0]         half_max;
  logic               wrap;

  assign half_max = (4'd1 << div_reg) - 4'd1;
  assign wrap     = (hp_cnt_reg == half_max);

  assign bus.clk_out     = clk_out_reg;
  assign bus.oe          = oe_reg;
  assign bus.cpu_reset_n = cpu_reset_n_reg;
  assign bus.div_ack     = div_ack_reg;
  assign bus.hold_ack    = hold_ack_reg;
  assign bus.busy        = busy_reg;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_reg       <= STARTUP;
      clk_out_reg     <= 1'b0;
      oe_reg          <= 1'b0;
      cpu_reset_n_reg <= 1'b0;
      div_ack_reg     <= 1'b0;
      hold_ack_reg    <= 1'b0;
      busy_reg        <= 1'b1;
      div_reg         <= DIV_RESET;
      pend_div_reg    <= DIV_RESET;
      pend_valid_reg  <= 1'b0;
      hold_flag_reg   <= 1'b0;
      ack_pend_reg    <= 1'b0;
      hp_cnt_reg      <= 4'd0;
      cyc_cnt_reg     <= '0;
      gap_cnt_reg     <= '0;
    end else begin
      div_ack_reg <= 1'b0;
      case (state_reg)
        STARTUP: begin
          if (wrap) begin
            hp_cnt_reg  <= 4'd0;
            clk_out_reg <= ~clk_out_reg;
            // Only falling toggles count towards the reset stretch.
            if (clk_out_reg) begin
              if (cyc_cnt_reg != CNT_W'(RESET_CYCLES))
                cyc_cnt_reg <= cyc_cnt_reg + CNT_W'(1);
              if (cyc_cnt_reg == CNT_W'(RESET_CYCLES - 1)) begin
                cpu_reset_n_reg <= 1'b1;
                busy_reg        <= 1'b0;
                state_reg       <= RUN;
              end
            end
          end else begin
            hp_cnt_reg <= hp_cnt_reg + 4'd1;
          end
        end

        RUN: begin
          if (wrap) begin
            hp_cnt_reg  <= 4'd0;
            clk_out_reg <= ~clk_out_reg;
          end else begin
            hp_cnt_reg <= hp_cnt_reg + 4'd1;
          end
          // A divisor change takes priority; a hold still pending is picked up on return.
          if (bus.div_req) begin
            pend_div_reg   <= bus.div_sel;
            pend_valid_reg <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= DRAIN;
          end else if (bus.hold_req) begin
            hold_flag_reg <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= DRAIN;
          end
        end

        DRAIN: begin
          // Any wrap either falls the clock or suppresses its rise, so the line ends low.
          if (wrap) begin
            hp_cnt_reg  <= 4'd0;
            clk_out_reg <= 1'b0;
            gap_cnt_reg <= '0;
            state_reg   <= PARK;
          end else begin
            hp_cnt_reg <= hp_cnt_reg + 4'd1;
          end
        end

        PARK: begin
          clk_out_reg <= 1'b0;
          if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
            gap_cnt_reg <= '0;
            if (pend_valid_reg) begin
              div_reg        <= pend_div_reg;
              pend_valid_reg <= 1'b0;
              ack_pend_reg   <= 1'b1;
              state_reg      <= RESUME;
            end else if (hold_flag_reg) begin
              oe_reg       <= 1'b1;
              hold_ack_reg <= 1'b1;
              state_reg    <= HELD;
            end else begin
              state_reg <= RESUME;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end

        RESUME: begin
          div_ack_reg  <= ack_pend_reg;
          ack_pend_reg <= 1'b0;
          hp_cnt_reg   <= 4'd0;
          busy_reg     <= 1'b0;
          state_reg    <= RUN;
        end

        HELD: begin
          clk_out_reg <= 1'b0;
          if (bus.div_req) begin
            pend_div_reg   <= bus.div_sel;
            pend_valid_reg <= 1'b1;
          end
          if (!bus.hold_req) begin
            oe_reg        <= 1'b0;
            hold_ack_reg  <= 1'b0;
            hold_flag_reg <= 1'b0;
            gap_cnt_reg   <= '0;
            state_reg     <= PARK;
          end
        end

        default: begin
          state_reg <= STARTUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_sequencer.sv
// Directed bench for clock_sequencer: startup stretch, divisor switch, hold,
// simultaneous requests, and reset out of HELD.
module tb_clock_sequencer;

  logic clk_in;
  logic reset;
  int   tests;
  int   fails;
  int   cyc;

  clock_sequencer_if bus ();

  clock_sequencer #(
    .RESET_CYCLES (8),
    .GAP_CYCLES   (4),
    .DIV_RESET    (2'd1)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input int n, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int n, input logic e_clk, input logic e_oe,
                           input logic e_rst, input logic e_ack, input logic e_hold,
                           input logic e_busy);
    check({tag, ".clk_out"},     n, bus.clk_out,     e_clk);
    check({tag, ".oe"},          n, bus.oe,          e_oe);
    check({tag, ".cpu_reset_n"}, n, bus.cpu_reset_n, e_rst);
    check({tag, ".div_ack"},     n, bus.div_ack,     e_ack);
    check({tag, ".hold_ack"},    n, bus.hold_ack,    e_hold);
    check({tag, ".busy"},        n, bus.busy,        e_busy);
  endtask

  // Startup at /4 with a stray div_req at edge 10; cpu_reset_n rises at edge 32.
  task automatic run_startup(input string tag);
    for (int n = 1; n <= 40; n++) begin
      bus.div_req = (n == 10);
      bus.div_sel = 2'd3;
      tick();
      check_all(tag, n, 1'((n >> 1) & 1), 1'b0, (n >= 32), 1'b0, 1'b0, (n < 32));
    end
    $display("[TB] %s: startup sequence checked through edge 40", tag);
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    cyc          = 0;
    reset        = 1'b0;
    bus.div_sel  = 2'd0;
    bus.div_req  = 1'b0;
    bus.hold_req = 1'b0;

    repeat (3) tick();
    check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("[TB] reset values checked");

    reset = 1'b1;
    run_startup("startup");

    // Switch /4 -> /16: park from edge 42, div_ack at 47, high phase edges 55..62.
    for (int n = 41; n <= 63; n++) begin
      bus.div_req = (n == 41);
      bus.div_sel = 2'd3;
      tick();
      check_all("div_switch", n, (n >= 55 && n < 63), 1'b0, 1'b1, (n == 47), 1'b0,
                (n >= 41 && n < 47));
    end
    $display("[TB] divisor switch to /16 checked");

    // Hold: HELD at edge 75, release at 81, resume at 86, next rise at 94.
    for (int n = 64; n <= 94; n++) begin
      bus.hold_req = (n >= 65 && n <= 80);
      tick();
      check_all("hold", n, (n >= 94), (n >= 75 && n < 81), 1'b1, 1'b0, (n >= 75 && n < 81),
                (n >= 65 && n < 86));
    end
    $display("[TB] hold request and release checked");

    // div_req(/2) and hold_req together: div_ack at 107, one-cycle high at 108, HELD at 113.
    for (int n = 95; n <= 115; n++) begin
      bus.div_req  = (n == 96);
      bus.div_sel  = 2'd0;
      bus.hold_req = (n >= 96);
      tick();
      check_all("div_and_hold", n, (n < 102) || (n == 108), (n >= 113), 1'b1, (n == 107),
                (n >= 113), (n >= 96 && n != 107));
    end
    $display("[TB] simultaneous divisor and hold requests checked");

    reset        = 1'b0;
    bus.hold_req = 1'b0;
    bus.div_req  = 1'b0;
    tick();
    check_all("reset_in_held", 116, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("[TB] reset while held checked");
    tick();

    reset = 1'b1;
    run_startup("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_sequencer.md
Name: clock_sequencer

Overview:
- Sequences the CPU clock line driven by the CPLD: generates the divided CPU clock (`clk_out`) and its active-low tri-state enable (`oe`).
- Holds the 68000 in reset until the clock has run for a fixed number of CPU cycles.
- Performs glitch-free divisor changes on request.
- Releases the clock line to an external master on hold request.
- Sits between the board oscillator (`clk_in`) and the top-level tri-state clock driver.

Parameters:
- RESET_CYCLES, 1024, full `clk_out` periods with `cpu_reset_n` held low after the clock starts.
- GAP_CYCLES, 4, `clk_in` cycles the clock stays parked low during a divisor switch or before hold acknowledge.
- DIV_RESET, 2'd1, divisor select loaded at reset.

Ports:
- clk_in  input  1  board oscillator; sole clock.
- reset  input  1  synchronous, active-low reset.
- div_sel  input  2  requested divisor: half-period = 2^div_sel `clk_in` cycles (/2, /4, /8, /16).
- div_req  input  1  single-cycle pulse requesting a switch to `div_sel`; `div_sel` sampled on the same edge.
- hold_req  input  1  level; external master requests the clock line.
- clk_out  output  1  registered divided CPU clock.
- oe  output  1  active-low driver enable; 1 means the top-level drives Z.
- cpu_reset_n  output  1  CPU reset, active low.
- div_ack  output  1  single-cycle pulse when the new divisor is in effect.
- hold_ack  output  1  level; the line is released while high.
- busy  output  1  high in any state other than RUN.

Behaviour:
- Reset: all logic is sampled on the `clk_in` rising edge while `reset`=0. Reset values:
  - state=STARTUP
  - `clk_out`=0, `oe`=0, `cpu_reset_n`=0, `div_ack`=0, `hold_ack`=0, `busy`=1
  - divisor register=DIV_RESET, half-period counter=0, cycle counter=0
- Reset asserted mid-operation aborts any switch or hold immediately. Pending requests are discarded.
- Divider, active in STARTUP and RUN only:
  - Counter runs 0..(2^div-1). `clk_out` toggles on the wrap.
  - The first toggle after entering STARTUP or RUN occurs 2^div cycles later. No runt phase.
- STARTUP:
  - Counts falling edges of `clk_out`.
  - After RESET_CYCLES falling edges: `cpu_reset_n`<=1 on the same edge as that falling toggle, then go to RUN.
  - `div_req` and `hold_req` are ignored in STARTUP. A `div_req` pulse is dropped. `hold_req` is serviced once in RUN if still high.
- RUN:
  - `busy`=0.
  - A `div_req` latches `div_sel` into a pending register and moves to DRAIN.
  - `hold_req`=1 moves to DRAIN with the hold flag set.
  - Simultaneous `div_req` and `hold_req`: the divisor change wins. The hold is serviced after RESUME if still asserted.
- DRAIN:
  - Keeps dividing until `clk_out` is low at a counter wrap: a falling toggle just occurred, or a rising toggle is suppressed if the wrap comes while `clk_out` is high.
  - Then clears the counter and enters PARK. `clk_out` is guaranteed 0 in PARK.
- PARK:
  - `clk_out` held 0 for GAP_CYCLES `clk_in` cycles.
  - Then: divisor switch → load divisor from pending, go to RESUME. Hold → `oe`<=1, `hold_ack`<=1, go to HELD.
- RESUME:
  - One cycle. Pulse `div_ack`=1, go to RUN with counter=0.
  - The next `clk_out` rising edge occurs 2^div cycles later.
- HELD:
  - `clk_out`=0, `oe`=1, `hold_ack`=1.
  - On `hold_req`=0: `hold_ack`<=0 and `oe`<=0 on the same edge, then enter PARK (hold flag cleared) for GAP_CYCLES with the line driven low.
  - Then RESUME without `div_ack`, since no divisor change occurred.
  - A `div_req` in HELD is latched and applied at that RESUME, and `div_ack` is pulsed.
- `cpu_reset_n` stays 1 through divisor switches and holds.
- Minimum high or low phase of `clk_out` is never shorter than 2^min(old,new) `clk_in` cycles.
- Counters: half-period counter 4 bits; RESET_CYCLES counter width $clog2(RESET_CYCLES+1). No wrap beyond terminal count; the counter saturates.

Test Plan:
- Release reset, RESET_CYCLES=8, DIV_RESET=1 → `clk_out` period 4 `clk_in` cycles; `cpu_reset_n` rises on the 8th falling edge (cycle 32 after reset release); `oe`=0 throughout.
- In RUN at /4, pulse `div_req` with `div_sel`=3 → `clk_out` parks low ≥4 cycles, `div_ack` pulses once, new high phase is exactly 8 cycles, no phase shorter than 2.
- `hold_req`=1 in RUN → `clk_out` ends low, 4-cycle park, then `oe`=1 and `hold_ack`=1. Drop `hold_req` → `oe`=0 same edge as `hold_ack`=0, 4-cycle low, clock resumes, no `div_ack`.
- `div_req` (`div_sel`=0) and `hold_req` rise on the same edge → `div_ack` pulse and half-period 1 observed first, then hold entered.
- Pulse `div_req` during STARTUP → ignored, divisor unchanged, no `div_ack`.
- Assert `reset` while in HELD → next edge `oe`=0, `clk_out`=0, `cpu_reset_n`=0, `hold_ack`=0, STARTUP restarts full count.
